vga_sync_generator: RTL and testbench
=====================================

Name: vga_sync_generator

Overview:
Timing source for the VGA controller. It produces the scanner coordinates pix_x and pix_y, plus hsync, vsync, video_on, the pixel-rate enable and a frame marker. The pixel generator consumes pix_x and pix_y to decide each pixel's colour, and the top level gates RGB with video_on. Default timing is 640x480 at 60 Hz, derived from a 100 MHz CLK divided by 4.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, CLK cycles per pixel; legal values are 1 or more

Ports:
CLK  input  1  system clock (100 MHz)
RST_N  input  1  asynchronous active-low reset
pix_x  output  10  current horizontal count, 0..H_TOTAL-1
pix_y  output  10  current vertical count, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  high while the current coordinate is in the visible area
p_tick  output  1  pixel enable; high for one CLK in each CLK_DIV cycles
frame_start  output  1  one-CLK pulse when the counters load (0,0)

Behaviour:
- Interface (already decided): one clock, CLK; reset RST_N is asynchronous and active-low.
- Derived constants: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800). V_TOTAL = the vertical equivalent (525). Both must be 1024 or less to fit 10 bits.
- Divider: register d counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick = (d == CLK_DIV-1), decoded from the register, so there is no path from the inputs.
  - With CLK_DIV = 1, p_tick is constantly 1 after reset.
- Counters advance on the CLK edge where p_tick = 1:
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - On an h wrap, v_count increments; at V_TOTAL-1 it wraps to 0.
  - pix_x = h_count and pix_y = v_count, both registered. Coordinates hold for exactly CLK_DIV CLK cycles.
- Status outputs are registered and computed from the next counter values, so they are always consistent with pix_x/pix_y in the same cycle:
  - hsync = 0 iff H_DISPLAY+H_FRONT <= pix_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= pix_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY).
- frame_start is set on the edge that loads (0,0) and cleared on the next CLK edge. It is exactly one CLK wide for every CLK_DIV.
- Reset (asynchronous, RST_N = 0), applied immediately without waiting for a CLK edge:
  - d = 0, pix_x = H_TOTAL-1, pix_y = V_TOTAL-1.
  - hsync = 1, vsync = 1, video_on = 0, frame_start = 0, p_tick = 0 (when CLK_DIV > 1).
  - The first tick after release therefore loads (0,0) and pulses frame_start, so every frame starts clean.
- Reset release: the first p_tick occurs CLK_DIV-1 CLK edges after release. The counters reach (0,0) on edge CLK_DIV.
- Reset mid-frame: all state is abandoned with no partial-line completion, and the next frame starts from (0,0) as above.
- Latency: the pixel generator registers RGB one CLK after the coordinates. The top level applies the same one-CLK register to hsync, vsync and video_on. This block does not add that delay.
- Simultaneous h wrap and v wrap at (799,524): one tick goes to (0,0), sets frame_start, and drives vsync = 1, hsync = 1, video_on = 1 together.
- No other inputs, and no illegal states are reachable. The counters never exceed TOTAL-1 because comparisons use == TOTAL-1.

Test Plan:
1. Release RST_N after 5 CLKs -> p_tick high on CLK cycles 3, 7, 11, ... after release; (pix_x, pix_y) goes from (799,524) to (0,0) at edge 4; frame_start is high for exactly 1 CLK; video_on = 1.
2. Run one line -> video_on falls when pix_x reaches 640; hsync is low for pix_x 656..751, i.e. 384 CLKs; the line period is 3200 CLKs.
3. Observe line and frame wraps -> pix_x goes 799 to 0 with pix_y incrementing; at (799,524) the next tick gives (0,0) with a frame_start pulse; pix_x and pix_y never exceed 799 and 524.
4. Run full frames -> vsync is low for lines 490..491, i.e. 6400 CLKs; the frame_start period is 1,680,000 CLKs; video_on is high for 1,228,800 CLKs per frame.
5. Assert RST_N low between clock edges at (320,200) -> outputs change immediately to pix (799,524), video_on 0, hsync 1, vsync 1; the restart behaves as in scenario 1.
6. Set CLK_DIV=1 -> p_tick is constantly 1; pix_x increments every CLK; the frame period is 420,000 CLKs; frame_start is still 1 CLK wide.

Source files
------------

// File: rtl/vga_sync_generator.sv
// VGA timing source: pixel-rate divider, scan counters and registered sync/blank status.
// Status outputs are computed from the next counter values so they line up with pix_x/pix_y.
module vga_sync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] d;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          hsync_next;
    logic          vsync_next;
    logic          video_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d <= '0;
        end else if (d == D_LAST) begin
            d <= '0;
        end else begin
            d <= d + DW'(1);
        end
    end

    // Decoded from the divider register only; with CLK_DIV = 1 this is tied high.
    assign p_tick = (d == D_LAST);

    assign h_wrap = (pix_x == H_LAST);
    assign v_wrap = (pix_y == V_LAST);

    always_comb begin
        h_next = pix_x + 10'd1;
        v_next = pix_y;
        if (h_wrap) begin
            h_next = '0;
            v_next = v_wrap ? '0 : pix_y + 10'd1;
        end
    end

    always_comb begin
        hsync_next = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
        vsync_next = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        video_next = (h_next < H_VIS) && (v_next < V_VIS);
    end

    // Reset parks the scan at the last coordinate so the first tick loads (0,0).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= p_tick && h_wrap && v_wrap;
            if (p_tick) begin
                pix_x    <= h_next;
                pix_y    <= v_next;
                hsync    <= hsync_next;
                vsync    <= vsync_next;
                video_on <= video_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Randomised-reset bench for vga_sync_generator against a closed-form timing model.
// Three instances: default 640x480/div4, a small raster at div4 and the same small raster at div1.
module tb_vga_sync_generator;

    logic CLK;
    logic RST_N;
    logic started;
    longint k;
    int total;
    int bad;

    logic [9:0] def_x, def_y, sm_x, sm_y, one_x, one_y;
    logic def_hs, def_vs, def_vo, def_pt, def_fs;
    logic sm_hs, sm_vs, sm_vo, sm_pt, sm_fs;
    logic one_hs, one_vs, one_vo, one_pt, one_fs;

    vga_sync_generator u_def (
        .CLK(CLK), .RST_N(RST_N), .pix_x(def_x), .pix_y(def_y), .hsync(def_hs),
        .vsync(def_vs), .video_on(def_vo), .p_tick(def_pt), .frame_start(def_fs)
    );

    vga_sync_generator #(
        .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(4)
    ) u_sm (
        .CLK(CLK), .RST_N(RST_N), .pix_x(sm_x), .pix_y(sm_y), .hsync(sm_hs),
        .vsync(sm_vs), .video_on(sm_vo), .p_tick(sm_pt), .frame_start(sm_fs)
    );

    vga_sync_generator #(
        .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
    ) u_one (
        .CLK(CLK), .RST_N(RST_N), .pix_x(one_x), .pix_y(one_y), .hsync(one_hs),
        .vsync(one_vs), .video_on(one_vo), .p_tick(one_pt), .frame_start(one_fs)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // k = CLK edges since reset release; the model derives everything from it.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) k <= 0;
        else        k <= k + 1;
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs;
        logic vs;
        logic vo;
        logic pt;
        logic fs;
    } exp_t;

    function automatic exp_t model(input longint kk, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb, input int div);
        exp_t e;
        longint ht, vt, n, x, y;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        n  = kk / div;
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = (n - 1) % ht;
            y = ((n - 1) / ht) % vt;
        end
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.hs = !((x >= hd + hf) && (x < hd + hf + hsw));
        e.vs = !((y >= vd + vf) && (y < vd + vf + vsw));
        e.vo = (x < hd) && (y < vd);
        e.pt = ((kk % div) == div - 1);
        e.fs = (kk > 0) && ((kk % div) == 0) && (((n - 1) % (ht * vt)) == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (started) begin
            chk("def", 32'({def_x, def_y, def_hs, def_vs, def_vo, def_pt, def_fs}),
                32'(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 4)));
            chk("sm", 32'({sm_x, sm_y, sm_hs, sm_vs, sm_vo, sm_pt, sm_fs}),
                32'(model(k, 10, 2, 3, 2, 6, 1, 2, 2, 4)));
            chk("one", 32'({one_x, one_y, one_hs, one_vs, one_vo, one_pt, one_fs}),
                32'(model(k, 10, 2, 3, 2, 6, 1, 2, 2, 1)));
        end
    end

    // Hand-computed pins for the first edges after a reset release.
    task automatic post_release_checks();
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK);
            #1;
            if (i == 1) begin
                chk("one_fs_e1", 32'(one_fs), 32'd1);
                chk("one_x_e1", 32'(one_x), 32'd0);
                chk("def_x_e1", 32'(def_x), 32'd799);
            end
            if (i == 2) begin
                chk("one_fs_e2", 32'(one_fs), 32'd0);
                chk("one_x_e2", 32'(one_x), 32'd1);
                chk("def_pt_e2", 32'(def_pt), 32'd0);
            end
            if (i == 3) chk("def_pt_e3", 32'(def_pt), 32'd1);
            if (i == 4) begin
                chk("def_xy_e4", 32'({def_x, def_y}), 32'd0);
                chk("def_fs_e4", 32'(def_fs), 32'd1);
                chk("def_vo_e4", 32'({def_vo, def_hs, def_vs}), 32'b111);
                chk("sm_xy_e4", 32'({sm_x, sm_y}), 32'd0);
            end
            if (i == 5) begin
                chk("def_fs_e5", 32'(def_fs), 32'd0);
                chk("def_xy_e5", 32'({def_x, def_y}), 32'd0);
            end
        end
    endtask

    task automatic frame_stats(input bit use_one, input int exp_per, input int exp_vlow,
                               input int exp_von);
        int t, per, vlow, von;
        t = 0;
        while (!(use_one ? one_fs : sm_fs) && t < 2000) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk("frame_seen", 32'(use_one ? one_fs : sm_fs), 32'd1);
        per = 0;
        vlow = 0;
        von = 0;
        do begin
            @(posedge CLK);
            #1;
            per++;
            if (!(use_one ? one_vs : sm_vs)) vlow++;
            if (use_one ? one_vo : sm_vo) von++;
        end while (!(use_one ? one_fs : sm_fs) && per < 2000);
        chk("frame_period", 32'(per), 32'(exp_per));
        chk("vsync_low", 32'(vlow), 32'(exp_vlow));
        chk("video_on_cnt", 32'(von), 32'(exp_von));
    endtask

    task automatic def_line_stats();
        int t, hlow, per;
        t = 0;
        while (!(def_x == 10'd0 && def_pt) && t < 4000) begin
            @(posedge CLK);
            #1;
            t++;
        end
        hlow = 0;
        per = 0;
        do begin
            @(posedge CLK);
            #1;
            per++;
            if (!def_hs) hlow++;
        end while (!(def_x == 10'd0 && def_pt) && per < 4000);
        chk("def_line_period", 32'(per), 32'd3200);
        chk("def_hsync_low", 32'(hlow), 32'd384);
    endtask

    initial begin
        total = 0;
        bad = 0;
        started = 1'b0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        started = 1'b1;
        #1;
        chk("rst_def", 32'({def_x, def_y, def_hs, def_vs, def_vo, def_pt, def_fs}),
            32'({10'd799, 10'd524, 5'b11000}));
        repeat (5) @(posedge CLK);
        #2 RST_N = 1'b1;
        post_release_checks();
        frame_stats(1'b0, 748, 136, 240);
        frame_stats(1'b1, 187, 34, 60);
        def_line_stats();

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(3000, 12000)) @(posedge CLK);
            #($urandom_range(1, 8));
            RST_N = 1'b0;
            #1;
            chk("midrst_def", 32'({def_x, def_y, def_hs, def_vs, def_vo, def_pt, def_fs}),
                32'({10'd799, 10'd524, 5'b11000}));
            chk("midrst_sm", 32'({sm_x, sm_y, sm_vo, sm_fs}), 32'({10'd16, 10'd10, 2'b00}));
            repeat ($urandom_range(1, 4)) @(posedge CLK);
            #($urandom_range(1, 8));
            RST_N = 1'b1;
            post_release_checks();
        end
        repeat (2000) @(posedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
